// File: rtl/mem_access_ctrl.sv
// Memory access controller: 2-entry request FIFO feeding a single-port memory
// through an IDLE/ISSUE/CAPTURE/RESP sequencer with one outstanding read.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              wr_done,
   output logic              busy,
   output logic [ADDR_W-1:0] M_add,
   output logic [DATA_W-1:0] M_wd,
   output logic              M_we,
   output logic              M_re,
   input  logic [DATA_W-1:0] M_rd
);

   localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

   state_e            state_q, state_d;
   logic [1:0]        count_q, count_d;
   logic [EntW-1:0]   fifo0_q, fifo0_d;
   logic [EntW-1:0]   fifo1_q, fifo1_d;
   logic [EntW-1:0]   cur_q, cur_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              wr_done_q, wr_done_d;

   logic              push, pop;
   logic [EntW-1:0]   req_entry;
   logic              cur_write;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;

   assign req_entry = {req_write, req_addr, req_wdata};
   assign {cur_write, cur_addr, cur_wdata} = cur_q;

   // Ready depends on occupancy only, so a full FIFO never accepts even if it pops.
   assign req_ready  = (count_q < 2'd2);
   assign push       = req_valid & req_ready;
   assign busy       = (count_q != 2'd0) | (state_q != StIdle);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign wr_done    = wr_done_q;

   // FIFO: fifo0 is always the head; a pop shifts fifo1 down.
   always_comb begin
      fifo0_d = fifo0_q;
      fifo1_d = fifo1_q;
      if (pop) begin
         fifo0_d = fifo1_q;
         fifo1_d = '0;
      end
      if (push) begin
         if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
            fifo0_d = req_entry;
         end else begin
            fifo1_d = req_entry;
         end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      pop          = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      wr_done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != 2'd0) begin
               pop     = 1'b1;
               cur_d   = fifo0_q;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (cur_write) begin
               wr_done_d = 1'b1;
               if (count_q != 2'd0) begin
                  pop   = 1'b1;
                  cur_d = fifo0_q;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            resp_data_d  = M_rd;
            resp_valid_d = 1'b1;
            state_d      = StResp;
         end
         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               if (count_q != 2'd0) begin
                  pop     = 1'b1;
                  cur_d   = fifo0_q;
                  state_d = StIssue;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      M_we  = 1'b0;
      M_re  = 1'b0;
      M_add = '0;
      M_wd  = '0;
      if (state_q == StIssue) begin
         M_we  = cur_write;
         M_re  = ~cur_write;
         M_add = cur_addr;
         M_wd  = cur_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         count_q      <= 2'd0;
         fifo0_q      <= '0;
         fifo1_q      <= '0;
         cur_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         wr_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         fifo0_q      <= fifo0_d;
         fifo1_q      <= fifo1_d;
         cur_q        <= cur_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         wr_done_q    <= wr_done_d;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: 16x4 memory model, directed scenarios and random traffic
// checked by a negedge monitor against an in-order transaction-level reference.
module tb_mem_access_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_ready, req_write;
   logic [3:0] req_addr, req_wdata;
   logic       resp_valid, resp_ready;
   logic [3:0] resp_data;
   logic       wr_done, busy;
   logic [3:0] M_add, M_wd, M_rd;
   logic       M_we, M_re;

   mem_access_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .wr_done    (wr_done),
      .busy       (busy),
      .M_add      (M_add),
      .M_wd       (M_wd),
      .M_we       (M_we),
      .M_re       (M_re),
      .M_rd       (M_rd)
   );

   always #5 clk = ~clk;

   // Attached memory: synchronous write, registered read.
   logic [3:0] mem [16];
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      mem[1] = 4'h1;
      mem[2] = 4'h5;
   end
   always @(posedge clk) begin
      if (M_we) mem[M_add] <= M_wd;
      if (M_re) M_rd <= mem[M_add];
   end

   typedef struct packed {
      logic       w;
      logic [3:0] a;
      logic [3:0] d;
   } op_t;

   op_t        op_q[$];
   logic [3:0] rd_q[$];
   logic [3:0] ref_mem [16];
   int         vectors = 0;
   int         miscompares = 0;
   int         acc_cnt, iss_cnt;

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
      ref_mem[1] = 4'h1;
      ref_mem[2] = 4'h5;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: issued ops and responses are matched against the reference order;
   // accepted requests are applied to the reference at the sampling point before the edge.
   initial begin
      logic       prev_we, prev_hold;
      logic [3:0] prev_data;
      op_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            op_q.delete();
            rd_q.delete();
            acc_cnt   = 0;
            iss_cnt   = 0;
            prev_we   = 1'b0;
            prev_hold = 1'b0;
            prev_data = 4'h0;
         end else begin
            check("we_re_exclusive", {31'd0, M_we & M_re}, 32'd0);
            if (M_we | M_re) begin
               iss_cnt++;
               if (op_q.size() == 0) begin
                  check("spurious_mem_op", {31'd0, M_we | M_re}, 32'd0);
               end else begin
                  e = op_q.pop_front();
                  check("op_kind", {31'd0, M_we}, {31'd0, e.w});
                  check("op_addr", {28'd0, M_add}, {28'd0, e.a});
                  if (e.w) check("op_wdata", {28'd0, M_wd}, {28'd0, e.d});
               end
            end else begin
               check("idle_bus", {24'd0, M_add, M_wd}, 32'd0);
            end
            check("wr_done_after_we", {31'd0, wr_done}, {31'd0, prev_we});
            check("req_ready_occ", {31'd0, req_ready}, {31'd0, (acc_cnt - iss_cnt) < 2});
            if (prev_hold) begin
               check("resp_hold", {31'd0, resp_valid}, 32'd1);
               check("resp_stable", {28'd0, resp_data}, {28'd0, prev_data});
            end
            if (resp_valid && resp_ready) begin
               if (rd_q.size() == 0) begin
                  check("spurious_resp", {31'd0, resp_valid}, 32'd0);
               end else begin
                  check("resp_data", {28'd0, resp_data}, {28'd0, rd_q.pop_front()});
               end
            end
            if (req_valid && req_ready) begin
               acc_cnt++;
               if (req_write) begin
                  ref_mem[req_addr] = req_wdata;
                  op_q.push_back('{w: 1'b1, a: req_addr, d: req_wdata});
               end else begin
                  op_q.push_back('{w: 1'b0, a: req_addr, d: 4'h0});
                  rd_q.push_back(ref_mem[req_addr]);
               end
            end
            prev_we   = M_we;
            prev_hold = resp_valid & ~resp_ready;
            prev_data = resp_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic w, input logic [3:0] a, input logic [3:0] d);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_resp"}, {27'd0, resp_valid, resp_data}, 32'd0);
      check({tag, "_wr_done_busy"}, {30'd0, wr_done, busy}, 32'd0);
      check({tag, "_mem_bus"}, {22'd0, M_we, M_re, M_add, M_wd}, 32'd0);
   endtask

   task automatic drain();
      int n;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      check("drain_idle", {31'd0, busy}, 32'd0);
      tick();
      tick();
      check("drain_queues", op_q.size() + rd_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n_wd;
      int         seen;
      logic [3:0] got;
      logic [6:0] we_hist;
      logic [3:0] saved;

      rst = 1'b1;
      set_req(1'b0, 1'b0, 4'h0, 4'h0);
      resp_ready = 1'b1;
      repeat (3) tick();
      check_reset("reset");
      rst = 1'b0;

      // Read addr 2 straight after reset release: M_re exactly one cycle after E1.
      set_req(1'b1, 1'b0, 4'h2, 4'h0);
      tick();
      req_valid = 1'b0;
      check("rd_lat_e0", {31'd0, M_re}, 32'd0);
      tick();
      check("rd_lat_e1", {27'd0, M_re, M_add}, {27'd1, 4'h2});
      tick();
      check("rd_lat_e2", {30'd0, M_re, resp_valid}, 32'd0);
      tick();
      check("rd_lat_e3", {27'd0, resp_valid, resp_data}, {27'd1, 4'h5});
      drain();

      // Write 7 then read 7 back to back.
      set_req(1'b1, 1'b1, 4'h7, 4'hA);
      tick();
      set_req(1'b1, 1'b0, 4'h7, 4'h0);
      tick();
      req_valid = 1'b0;
      n_wd = 0;
      seen = 0;
      got  = 4'h0;
      for (int c = 0; c < 10; c++) begin
         if (wr_done) n_wd++;
         if (resp_valid) begin
            seen++;
            got = resp_data;
         end
         tick();
      end
      check("wr_rd_wr_done", n_wd, 32'd1);
      check("wr_rd_seen", seen, 32'd1);
      check("wr_rd_data", {28'd0, got}, 32'hA);
      drain();

      // Three writes on consecutive cycles issue on consecutive cycles.
      set_req(1'b1, 1'b1, 4'h3, 4'h1);
      n_wd = 0;
      we_hist = '0;
      for (int c = 0; c < 7; c++) begin
         tick();
         we_hist[c] = M_we;
         if (wr_done) n_wd++;
         if (c == 0) set_req(1'b1, 1'b1, 4'h4, 4'h2);
         else if (c == 1) set_req(1'b1, 1'b1, 4'h5, 4'h3);
         else if (c == 2) req_valid = 1'b0;
      end
      check("wr3_issue_pattern", {25'd0, we_hist}, 32'b0001110);
      check("wr3_wr_done", n_wd, 32'd3);
      drain();

      // Stalled read response with the FIFO filling behind it.
      resp_ready = 1'b0;
      set_req(1'b1, 1'b0, 4'h1, 4'h0);
      tick();
      set_req(1'b1, 1'b1, 4'h5, 4'h9);
      tick();
      set_req(1'b1, 1'b0, 4'h2, 4'h0);
      tick();
      req_valid = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         check("stall_resp", {27'd0, resp_valid, resp_data}, {27'd1, 4'h1});
         check("stall_full", {29'd0, req_ready, M_we, M_re}, 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      check("stall_release", {26'd0, resp_valid, M_we, M_add}, {26'd1, 4'h5});
      drain();

      // Reset during CAPTURE with a write queued behind the read.
      saved = ref_mem[9];
      set_req(1'b1, 1'b0, 4'h2, 4'h0);
      tick();
      set_req(1'b1, 1'b1, 4'h9, ~saved);
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_reset("midrst");
      tick();
      tick();
      rst = 1'b0;
      ref_mem[9] = saved;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (resp_valid || wr_done || M_we || M_re) seen++;
         tick();
      end
      check("midrst_quiet", seen, 32'd0);
      check("midrst_mem", {28'd0, mem[9]}, {28'd0, saved});

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         resp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 4, address width; DATA_W, default 4, data width; none other.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  requester presents a memory operation.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  ADDR_W  target address.
REQ-008 req_wdata  input  DATA_W  write data; ignored for reads.
REQ-009 resp_valid  output  1  read data available.
REQ-010 resp_ready  input  1  requester accepts read data.
REQ-011 resp_data  output  DATA_W  read data.
REQ-012 wr_done  output  1  one-cycle pulse: write issued to memory.
REQ-013 busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-014 M_add  output  ADDR_W  memory address.
REQ-015 M_wd  output  DATA_W  memory write data.
REQ-016 M_we  output  1  memory write enable.
REQ-017 M_re  output  1  memory read enable.
REQ-018 M_rd  input  DATA_W  memory read data, registered in memory, valid the cycle after the M_re edge.

Function
REQ-019 Request FIFO SHALL be 2 entries deep, each holding {write, addr, wdata}, with a 2-bit count 0..2.
REQ-020 req_ready SHALL be 1 when count<2, combinational from count only; no pop-through when full.
REQ-021 A push SHALL occur on an edge where req_valid & req_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP.
REQ-023 IDLE: if count>0, pop head into current-op register and go to ISSUE; else stay.
REQ-024 ISSUE: drive M_add/M_wd from current op; M_we = op.write, M_re = ~op.write; exactly one cycle.
REQ-025 ISSUE with write: assert wr_done in the following cycle; if count>0 pop next and stay in ISSUE, else go to IDLE (back-to-back writes, 1 per cycle).
REQ-026 ISSUE with read: go to CAPTURE.
REQ-027 CAPTURE: M_we=M_re=0; at end of cycle latch M_rd into resp_data, set resp_valid, go to RESP.
REQ-028 RESP: hold resp_valid and resp_data stable until resp_valid & resp_ready; on that edge clear resp_valid and go to ISSUE (popping head) if count>0, else IDLE.
REQ-029 Outside ISSUE, M_we, M_re SHALL be 0; M_add, M_wd SHALL be 0.
REQ-030 M_we and M_re SHALL never be 1 in the same cycle.
REQ-031 Latency: request pushed at edge E0 into empty idle unit -> M_re/M_we high in cycle after E1 -> memory acts at E2 -> wr_done high after E2; read resp_valid high after E3.
REQ-032 Only one read SHALL be outstanding; FIFO keeps accepting while in CAPTURE/RESP until full.
REQ-033 Addresses SHALL pass through unmodified; no wrap or arithmetic on address or data.

Reset
REQ-034 rst SHALL asynchronously force: FSM IDLE, count 0, FIFO contents and current op cleared, resp_valid 0, resp_data 0, wr_done 0, M_we 0, M_re 0, M_add 0, M_wd 0, busy 0, req_ready 1.
REQ-035 rst asserted mid-operation (any state) SHALL discard all queued and in-flight operations with no response or wr_done afterward.
REQ-036 First request accepted on the first rising edge after rst deasserts.

Verification (16x4 data memory attached; reset contents addr1=1, addr2=5, others 0)
REQ-037 After reset, read addr 2, resp_ready=1 -> M_re high exactly 1 cycle with M_add=2, resp_valid after E3 with resp_data=5.
REQ-038 Write addr 7 data 0xA then read addr 7 back-to-back -> wr_done one pulse, M_we and M_re never coincident, resp_data=0xA.
REQ-039 Three writes presented every cycle -> req_ready drops when count=2, writes issue on consecutive cycles in order, three wr_done pulses.
REQ-040 Read addr 1 with resp_ready=0 for 5 cycles while 2 further requests queue -> resp_data=1 held stable, req_ready=0 once full, queued ops issue only after handshake.
REQ-041 Assert rst during CAPTURE of a read with one write queued -> all outputs at reset values, no resp_valid, no wr_done, memory unchanged by the queued write.
